ring_phase_monitor: RTL and testbench
=====================================

Name: ring_phase_monitor

Overview:
Receive-end checker for the one-hot ring counter output bus. Samples the ring bus and decodes it to a binary phase index. Locks onto a correctly rotating sequence and flags any illegal or out-of-order code. Counts completed laps and sequence errors for status/debug logic downstream of the ring counter.

Parameters:
WIDTH, 4, number of ring bits (phases); must be >= 2
LOCK_CNT, 3, consecutive correct steps required to declare lock (>= 1)
LAP_W, 8, width of lap counter
ERR_W, 4, width of error counter
PW, $clog2(WIDTH), width of phase index (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
ring_in  input  WIDTH  ring code; bit k hot means phase k
in_valid  input  1  sample ring_in this cycle
clear  input  1  synchronous clear of lap_count and err_count
phase  output  PW  registered binary index of last legal sample
locked  output  1  high while FSM is in LOCKED
seq_err  output  1  one-cycle pulse on loss of lock
lap_count  output  LAP_W  completed laps while locked; wraps
err_count  output  ERR_W  loss-of-lock events; saturates at all-ones

Behaviour:
- Reset (async, rst=1): phase=0, locked=0, seq_err=0, lap_count=0, err_count=0, match=0, prev=0, state=HUNT.
- Legal sample: in_valid=1 and ring_in has exactly one bit set. Decoded index k is that bit position.
- Expected step: k == (prev+1) mod WIDTH. Sequence is 0,1,...,WIDTH-1,0.
- Cycles with in_valid=0: no state, counter or output change, except seq_err returns to 0.
- All outputs are registered. Effects of a sample appear the cycle after the sampling edge.
- State HUNT:
  - Legal sample that is the expected step with match>0: match++, prev=k, phase=k.
  - Any other legal sample: match=1, prev=k, phase=k.
  - Illegal sample (zero or multiple hot bits): match=0; phase and prev hold.
  - When match reaches LOCK_CNT: go to LOCKED, locked=1 on the same edge. With LOCK_CNT=3 this needs three consecutive legal sequential samples.
- State LOCKED:
  - Legal expected step: prev=k, phase=k.
  - If the step is WIDTH-1 -> 0, lap_count increments (mod 2^LAP_W).
  - Any other sample (illegal code, skip, repeat, or backward step): go to HUNT, locked=0, seq_err=1 for one cycle, err_count++ (saturating).
  - For a legal failing sample in LOCKED: match=1, prev=k, phase=k, so re-lock starts from that sample.
  - For an illegal failing sample: match=0 and phase holds.
- clear:
  - Zeroes lap_count and err_count on the next edge. FSM and phase are not affected.
  - If clear coincides with an increment event, clear wins (result 0).
- No lap is counted on the sample that achieves lock, even if that sample is phase 0.
- Reset mid-operation: immediate return to reset values regardless of state; no seq_err pulse.

Test Plan:
- Reset, then drive 1000,0100,0010,0001 pattern as phase 0..3 (ring_in=0001,0010,0100,1000) with in_valid=1 -> locked=1 after third sample; phase tracks 0,1,2,3.
- Locked, run 5 full laps -> lap_count=5, err_count=0, seq_err never asserted.
- Locked, inject ring_in=0110 -> next cycle seq_err=1 for exactly one cycle, locked=0, err_count=1, phase unchanged. Three further legal steps -> locked=1 again.
- Locked at phase 1, inject phase 3 (skip) -> seq_err pulse, err_count increments. Relock from phase 3 requires samples 0 then 1 (match 1->3) -> locked=1.
- Gap behaviour: in_valid toggling 1/0 with a legal sequence -> lock and lap counting are identical to the continuous run; outputs are frozen on in_valid=0 cycles.
- Force 20 errors -> err_count saturates at 15. Pulse clear together with a lap wrap -> lap_count=0, err_count=0. Assert rst while locked -> all outputs 0 immediately.

Source files
------------

// File: rtl/ring_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : ring_phase_monitor
//  Purpose  : Receive-end checker for a one-hot ring counter bus. Decodes
//             the ring code to a phase index, locks onto a correctly
//             rotating sequence, flags loss of lock, and counts laps and
//             sequence errors.
//  Revision : 1.0  initial release
// ============================================================================
module ring_phase_monitor #(
    parameter  int WIDTH    = 4,
    parameter  int LOCK_CNT = 3,
    parameter  int LAP_W    = 8,
    parameter  int ERR_W    = 4,
    localparam int PW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             in_valid,
    input  logic             clear,
    output logic [PW-1:0]    phase,
    output logic             locked,
    output logic             seq_err,
    output logic [LAP_W-1:0] lap_count,
    output logic [ERR_W-1:0] err_count
);

    // Match counter must be able to hold LOCK_CNT itself.
    localparam int              MW          = $clog2(LOCK_CNT + 1);
    localparam logic [PW-1:0]   LAST_PHASE  = PW'(WIDTH - 1);
    localparam logic [MW-1:0]   LOCK_TARGET = MW'(LOCK_CNT);
    localparam logic [MW-1:0]   MATCH_ONE   = MW'(1);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q,   state_d;
    logic [MW-1:0]      match_q,   match_d;
    logic [PW-1:0]      prev_q,    prev_d;
    logic [PW-1:0]      phase_q,   phase_d;
    logic               seq_err_q, seq_err_d;
    logic [LAP_W-1:0]   lap_q,     lap_d;
    logic [ERR_W-1:0]   err_q,     err_d;

    logic [PW-1:0]      dec_k;
    logic [PW-1:0]      next_exp;
    logic               legal;
    logic               is_step;

    // Decode the hot bit position; only meaningful when the code is one-hot.
    always_comb begin
        dec_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                dec_k = PW'(i);
            end
        end
    end

    assign legal    = in_valid && $onehot(ring_in);
    assign next_exp = (prev_q == LAST_PHASE) ? '0 : prev_q + 1'b1;
    assign is_step  = (dec_k == next_exp);

    // Next-state, sequence tracking and counter updates.
    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        prev_d    = prev_q;
        phase_d   = phase_q;
        seq_err_d = 1'b0;
        lap_d     = lap_q;
        err_d     = err_q;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (legal) begin
                        prev_d  = dec_k;
                        phase_d = dec_k;
                        if (is_step && (match_q != '0)) begin
                            match_d = match_q + 1'b1;
                        end else begin
                            match_d = MATCH_ONE;
                        end
                        if (match_d >= LOCK_TARGET) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (legal && is_step) begin
                        prev_d  = dec_k;
                        phase_d = dec_k;
                        // Wrapping back to phase 0 completes a lap.
                        if (dec_k == '0) begin
                            lap_d = lap_q + 1'b1;
                        end
                    end else begin
                        state_d   = HUNT;
                        seq_err_d = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        // A legal but wrong code seeds the re-lock attempt.
                        if (legal) begin
                            match_d = MATCH_ONE;
                            prev_d  = dec_k;
                            phase_d = dec_k;
                        end else begin
                            match_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    match_d = '0;
                end
            endcase
        end

        // Clear beats any simultaneous increment.
        if (clear) begin
            lap_d = '0;
            err_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            match_q   <= '0;
            prev_q    <= '0;
            phase_q   <= '0;
            seq_err_q <= 1'b0;
            lap_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            prev_q    <= prev_d;
            phase_q   <= phase_d;
            seq_err_q <= seq_err_d;
            lap_q     <= lap_d;
            err_q     <= err_d;
        end
    end

    assign phase     = phase_q;
    assign locked    = (state_q == LOCKED);
    assign seq_err   = seq_err_q;
    assign lap_count = lap_q;
    assign err_count = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_phase_monitor
//  Purpose  : Directed self-checking bench for ring_phase_monitor
//             (WIDTH=4, LOCK_CNT=3, LAP_W=8, ERR_W=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ring_phase_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] ring_in;
    logic       in_valid;
    logic       clear;
    logic [1:0] phase;
    logic       locked;
    logic       seq_err;
    logic [7:0] lap_count;
    logic [3:0] err_count;

    int total  = 0;
    int passed = 0;
    logic seen_err;

    ring_phase_monitor #(
        .WIDTH    (4),
        .LOCK_CNT (3),
        .LAP_W    (8),
        .ERR_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ring_in   (ring_in),
        .in_valid  (in_valid),
        .clear     (clear),
        .phase     (phase),
        .locked    (locked),
        .seq_err   (seq_err),
        .lap_count (lap_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample half a cycle early, then look 1 ns past the edge.
    task automatic step(input logic [3:0] r, input logic v, input logic c);
        @(negedge clk);
        ring_in  = r;
        in_valid = v;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [1:0] ph, input logic lk,
                           input logic se, input logic [7:0] lap, input logic [3:0] er);
        chk({tag, ".phase"},   32'(phase),     32'(ph));
        chk({tag, ".locked"},  32'(locked),    32'(lk));
        chk({tag, ".seq_err"}, 32'(seq_err),   32'(se));
        chk({tag, ".lap"},     32'(lap_count), 32'(lap));
        chk({tag, ".err"},     32'(err_count), 32'(er));
    endtask

    initial begin
        rst      = 1'b1;
        ring_in  = 4'b0000;
        in_valid = 1'b0;
        clear    = 1'b0;
        #12;
        chk_all("reset", 2'd0, 1'b0, 1'b0, 8'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        // Acquire lock: 0,1,2 -> locked after the third sample.
        step(4'b0001, 1'b1, 1'b0); chk_all("acq0", 2'd0, 1'b0, 1'b0, 8'd0, 4'd0);
        step(4'b0010, 1'b1, 1'b0); chk_all("acq1", 2'd1, 1'b0, 1'b0, 8'd0, 4'd0);
        step(4'b0100, 1'b1, 1'b0); chk_all("acq2", 2'd2, 1'b1, 1'b0, 8'd0, 4'd0);
        step(4'b1000, 1'b1, 1'b0); chk_all("acq3", 2'd3, 1'b1, 1'b0, 8'd0, 4'd0);

        // Five full laps while locked.
        seen_err = 1'b0;
        for (int l = 0; l < 5; l++) begin
            for (int p = 0; p < 4; p++) begin
                step(4'b0001 << p, 1'b1, 1'b0);
                seen_err = seen_err | seq_err;
            end
        end
        chk("laps5.seq_err_seen", 32'(seen_err), 32'd0);
        chk_all("laps5", 2'd3, 1'b1, 1'b0, 8'd5, 4'd0);

        // Illegal code while locked; pulse lasts one cycle, gap keeps state.
        step(4'b0110, 1'b1, 1'b0); chk_all("illegal", 2'd3, 1'b0, 1'b1, 8'd5, 4'd1);
        step(4'b1111, 1'b0, 1'b0); chk_all("illegal_gap", 2'd3, 1'b0, 1'b0, 8'd5, 4'd1);
        step(4'b0001, 1'b1, 1'b0); chk_all("relock0", 2'd0, 1'b0, 1'b0, 8'd5, 4'd1);
        step(4'b0010, 1'b1, 1'b0); chk_all("relock1", 2'd1, 1'b0, 1'b0, 8'd5, 4'd1);
        step(4'b0100, 1'b1, 1'b0); chk_all("relock2", 2'd2, 1'b1, 1'b0, 8'd5, 4'd1);

        // Walk to phase 1 (one lap on the 3->0 step), then skip to 3.
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0); chk_all("walk0", 2'd0, 1'b1, 1'b0, 8'd6, 4'd1);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0); chk_all("skip", 2'd3, 1'b0, 1'b1, 8'd6, 4'd2);
        step(4'b0001, 1'b1, 1'b0); chk_all("skip_r0", 2'd0, 1'b0, 1'b0, 8'd6, 4'd2);
        step(4'b0010, 1'b1, 1'b0); chk_all("skip_r1", 2'd1, 1'b1, 1'b0, 8'd6, 4'd2);

        // Gapped stream: in_valid=0 cycles freeze everything.
        step(4'b0100, 1'b0, 1'b0); chk_all("gap_a", 2'd1, 1'b1, 1'b0, 8'd6, 4'd2);
        step(4'b0100, 1'b1, 1'b0); chk_all("gap_b", 2'd2, 1'b1, 1'b0, 8'd6, 4'd2);
        step(4'b0001, 1'b0, 1'b0); chk_all("gap_c", 2'd2, 1'b1, 1'b0, 8'd6, 4'd2);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0); chk_all("gap_d", 2'd0, 1'b1, 1'b0, 8'd7, 4'd2);
        step(4'b0110, 1'b0, 1'b0); chk_all("gap_e", 2'd0, 1'b1, 1'b0, 8'd7, 4'd2);

        // Twenty loss-of-lock events: skip to 2, then 3, 0 re-locks (no lap).
        for (int e = 0; e < 20; e++) begin
            step(4'b0100, 1'b1, 1'b0);
            step(4'b1000, 1'b1, 1'b0);
            step(4'b0001, 1'b1, 1'b0);
        end
        chk_all("err_sat", 2'd0, 1'b1, 1'b0, 8'd7, 4'd15);

        // Run the lap counter up to 255, then clear on the wrapping lap.
        for (int l = 0; l < 248; l++) begin
            for (int p = 1; p < 4; p++) step(4'b0001 << p, 1'b1, 1'b0);
            step(4'b0001, 1'b1, 1'b0);
        end
        chk_all("lap255", 2'd0, 1'b1, 1'b0, 8'd255, 4'd15);
        for (int p = 1; p < 4; p++) step(4'b0001 << p, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b1); chk_all("clear_wrap", 2'd0, 1'b1, 1'b0, 8'd0, 4'd0);
        for (int p = 1; p < 4; p++) step(4'b0001 << p, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0); chk_all("after_clear", 2'd0, 1'b1, 1'b0, 8'd1, 4'd0);
        step(4'b0010, 1'b1, 1'b0); chk_all("pre_rst", 2'd1, 1'b1, 1'b0, 8'd1, 4'd0);

        // Asynchronous reset while locked, away from any clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("async_rst", 2'd0, 1'b0, 1'b0, 8'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        // An illegal code in HUNT restarts the match count.
        step(4'b0001, 1'b1, 1'b0); chk_all("h0", 2'd0, 1'b0, 1'b0, 8'd0, 4'd0);
        step(4'b0010, 1'b1, 1'b0); chk_all("h1", 2'd1, 1'b0, 1'b0, 8'd0, 4'd0);
        step(4'b0000, 1'b1, 1'b0); chk_all("h_bad", 2'd1, 1'b0, 1'b0, 8'd0, 4'd0);
        step(4'b0100, 1'b1, 1'b0); chk_all("h2", 2'd2, 1'b0, 1'b0, 8'd0, 4'd0);
        step(4'b1000, 1'b1, 1'b0); chk_all("h3", 2'd3, 1'b0, 1'b0, 8'd0, 4'd0);
        // Lock achieved on a phase-0 sample: no lap counted.
        step(4'b0001, 1'b1, 1'b0); chk_all("h_lock0", 2'd0, 1'b1, 1'b0, 8'd0, 4'd0);
        // Repeat of the same phase while locked is an error.
        step(4'b0001, 1'b1, 1'b0); chk_all("repeat", 2'd0, 1'b0, 1'b1, 8'd0, 4'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
